// File: rtl/pipe_stage_elastic_if.sv
// Handshake bundle for pipe_stage_elastic. The upstream and downstream beats, the flush and the
// performance counters travel together, so a stage boundary is a single port.
interface pipe_stage_elastic_if #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int CNT_W = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [NCH*WIDTH-1:0] in_data;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [NCH*WIDTH-1:0] out_data;
    logic [CNT_W-1:0]     flush_cnt;
    logic [CNT_W-1:0]     bubble_cnt;

    // master: the surrounding pipeline, which drives beats in and consumes beats out
    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, flush_cnt, bubble_cnt
    );

    // slave: the stage itself
    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, flush_cnt, bubble_cnt
    );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: NCH channels of WIDTH bits behind a 2-entry skid buffer, with a
// bubble-injecting flush and saturating flush/bubble counters.
module pipe_stage_elastic #(
    parameter int               WIDTH     = 32,
    parameter int               NCH       = 4,
    parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(32'h00000013),
    parameter int               CNT_W     = 16
) (
    input logic                clk,
    input logic                rst,
    pipe_stage_elastic_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    localparam logic [NCH*WIDTH-1:0] NOP_ALL = {NCH{NOP_VALUE}};
    localparam logic [CNT_W-1:0]     CNT_MAX = '1;

    state_t               state;
    logic [NCH*WIDTH-1:0] main_q;
    logic [NCH*WIDTH-1:0] skid_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [CNT_W-1:0]     flush_cnt_q;
    logic [CNT_W-1:0]     bubble_cnt_q;
    logic                 up_fire;
    logic                 down_fire;

    // Fires are taken from the registered flags, so in_ready never depends on out_ready.
    assign up_fire   = bus.in_valid & in_ready_q;
    assign down_fire = out_valid_q & bus.out_ready;

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_valid_q ? main_q : NOP_ALL;
    assign bus.flush_cnt  = flush_cnt_q;
    assign bus.bubble_cnt = bubble_cnt_q;

    // NOTE: sequential state uses non-blocking assignments only, so every register in this block
    // samples pre-edge values and the case arms cannot see each other's updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: both data entries are real registers and are reset explicitly, so no stale beat
            // can reappear after reset.
            state       <= EMPTY;
            main_q      <= NOP_ALL;
            skid_q      <= NOP_ALL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (bus.flush) begin
            state       <= EMPTY;
            main_q      <= NOP_ALL;
            skid_q      <= NOP_ALL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (up_fire) begin
                        state       <= ONE;
                        main_q      <= bus.in_data;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (up_fire && down_fire) begin
                        main_q <= bus.in_data;
                    end else if (up_fire) begin
                        state      <= TWO;
                        skid_q     <= bus.in_data;
                        in_ready_q <= 1'b0;
                    end else if (down_fire) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                TWO: begin
                    // Upstream is stalled here, so only the drain into main can happen.
                    if (down_fire) begin
                        state      <= ONE;
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (bus.flush && flush_cnt_q != CNT_MAX) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
            if (!out_valid_q && bubble_cnt_q != CNT_MAX) begin
                bubble_cnt_q <= bubble_cnt_q + 1'b1;
            end
        end
    end
endmodule
